vga_timing_gen: RTL and testbench

Parametrised, single-clock VGA raster timing generator: the next generation of the display sync counter. It produces horizontal/vertical sync, display-enable, pixel coordinates and line/frame start strobes for any mode set by parameters. A pixel-clock enable lets it run from the system clock, so it needs no derived line clock. It sits between the system clock and the pixel-fetch/framebuffer logic.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 62 ++++++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Purpose: shared VGA mode description, 640x480@60 defaults and axis-total helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_mode_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CW       = 10;

    localparam vga_mode_t VGA_640X480_H = '{active: VGA_H_ACTIVE, fp: VGA_H_FP,
                                            sync: VGA_H_SYNC, bp: VGA_H_BP};
    localparam vga_mode_t VGA_640X480_V = '{active: VGA_V_ACTIVE, fp: VGA_V_FP,
                                            sync: VGA_V_SYNC, bp: VGA_V_BP};

    // Regions are laid out active, front porch, sync, back porch.
    function automatic int axis_total(input vga_mode_t m);
        return m.active + m.fp + m.sync + m.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose: one raster axis: wrapping position counter with registered active/sync flags.
// Latency: en in cycle N -> cnt/active/sync updated in cycle N+1; wrap is combinational.
// Backpressure: none; en=0 freezes the counter and both flags.
// Ports: inputclk/reset_b (sync, active-high) | en advance | cnt position |
//        active in visible region | sync at POL level in sync region | wrap = advancing past last.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter bit POL    = 1'b0,
    parameter int CW     = VGA_CW
) (
    input  logic          inputclk,
    input  logic          reset_b,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          active,
    output logic          sync,
    output logic          wrap
);

    localparam vga_mode_t     MODE    = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
    localparam int            TOTAL   = axis_total(MODE);
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    // One extra bit so region bounds equal to 2**CW still compare correctly.
    localparam logic [CW:0]   ACT_END = (CW+1)'(ACTIVE);
    localparam logic [CW:0]   SYNC_LO = (CW+1)'(ACTIVE + FP);
    localparam logic [CW:0]   SYNC_HI = (CW+1)'(ACTIVE + FP + SYNC);

    logic [CW-1:0] cnt_nxt;
    logic [CW:0]   cnt_nxt_ext;

    assign wrap = en && (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (wrap) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    assign cnt_nxt_ext = {1'b0, cnt_nxt};

    // Flags are decoded from the next count so they line up with cnt itself.
    always_ff @(posedge inputclk) begin
        if (reset_b) begin
            cnt    <= LAST;
            active <= 1'b0;
            sync   <= ~POL;
        end else begin
            cnt    <= cnt_nxt;
            active <= (cnt_nxt_ext < ACT_END);
            sync   <= ((cnt_nxt_ext >= SYNC_LO) && (cnt_nxt_ext < SYNC_HI)) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA raster timing (syncs, display enables, coordinates, strobes).
// Latency: pix_en in cycle N -> all outputs updated in cycle N+1, mutually aligned.
// Backpressure: none; pix_en=0 holds every level output and zeroes the strobes.
// Ports: inputclk | reset_b (sync, active-high) | pix_en | hsync, vsync | Hdisplay, Vdisplay,
//        display | hrow (x in display, else 0) | vcolumn (y in Vdisplay, else 0) | line_start, frame_start.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CW         = VGA_CW
) (
    input  logic          inputclk,
    input  logic          reset_b,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          Hdisplay,
    output logic          Vdisplay,
    output logic          display,
    output logic [CW-1:0] hrow,
    output logic [CW-1:0] vcolumn,
    output logic          line_start,
    output logic          frame_start
);

    localparam vga_mode_t H_MODE  = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam vga_mode_t V_MODE  = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int        H_TOTAL = axis_total(H_MODE);
    localparam int        V_TOTAL = axis_total(V_MODE);
    localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);

    generate
        if (CW == 0 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_width
            $error("vga_timing_gen: zero-width timing parameter");
        end
        if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
        end
    endgenerate

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          v_en;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_in_nxt;
    logic          v_in_nxt;

    assign v_en = pix_en & h_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL), .CW(CW)
    ) u_h_axis (
        .inputclk(inputclk), .reset_b(reset_b), .en(pix_en),
        .cnt(hcnt), .active(Hdisplay), .sync(hsync), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL), .CW(CW)
    ) u_v_axis (
        .inputclk(inputclk), .reset_b(reset_b), .en(v_en),
        .cnt(vcnt), .active(Vdisplay), .sync(vsync), .wrap(v_wrap)
    );

    // Rebuild the next coordinates here so display/hrow/vcolumn are registered
    // alongside the axis flags rather than gated from them after the flops.
    always_comb begin
        h_nxt = hcnt;
        v_nxt = vcnt;
        if (h_wrap) begin
            h_nxt = '0;
        end else if (pix_en) begin
            h_nxt = hcnt + CW'(1);
        end
        if (v_wrap) begin
            v_nxt = '0;
        end else if (v_en) begin
            v_nxt = vcnt + CW'(1);
        end
    end

    assign h_in_nxt = ({1'b0, h_nxt} < H_ACT_END);
    assign v_in_nxt = ({1'b0, v_nxt} < V_ACT_END);

    always_ff @(posedge inputclk) begin
        if (reset_b) begin
            display     <= 1'b0;
            hrow        <= '0;
            vcolumn     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            display     <= h_in_nxt & v_in_nxt;
            hrow        <= (h_in_nxt & v_in_nxt) ? h_nxt : '0;
            vcolumn     <= v_in_nxt ? v_nxt : '0;
            // Strobes come from the wrap terms, which already include pix_en,
            // so they are single-cycle regardless of the enable duty cycle.
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en_d = 1'b0;
    logic pix_en_s = 1'b0;

    logic       hs_d, vs_d, hd_d, vd_d, disp_d, ls_d, fs_d;
    logic [9:0] hrow_d, vcol_d;
    logic       hs_s, vs_s, hd_s, vd_s, disp_s, ls_s, fs_s;
    logic [3:0] hrow_s, vcol_s;

    int n_total = 0;
    int n_bad   = 0;
    int pos     = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .inputclk(clk), .reset_b(rst), .pix_en(pix_en_d),
        .hsync(hs_d), .vsync(vs_d), .Hdisplay(hd_d), .Vdisplay(vd_d), .display(disp_d),
        .hrow(hrow_d), .vcolumn(vcol_d), .line_start(ls_d), .frame_start(fs_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(4)
    ) dut_s (
        .inputclk(clk), .reset_b(rst), .pix_en(pix_en_s),
        .hsync(hs_s), .vsync(vs_s), .Hdisplay(hd_s), .Vdisplay(vd_s), .display(disp_s),
        .hrow(hrow_s), .vcolumn(vcol_s), .line_start(ls_s), .frame_start(fs_s)
    );

    typedef struct {
        int hs, vs, hd, vd, disp, hrow, vcol, ls, fs;
    } obs_t;

    // sel 0 = default 640x480 instance, sel 1 = small mode; p = enabled pixels since reset.
    typedef struct {
        int sel, p, hs, vs, hd, vd, disp, hrow, vcol, ls, fs;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        if (sel == 0) begin
            o = '{int'(hs_d), int'(vs_d), int'(hd_d), int'(vd_d), int'(disp_d),
                  int'(hrow_d), int'(vcol_d), int'(ls_d), int'(fs_d)};
        end else begin
            o = '{int'(hs_s), int'(vs_s), int'(hd_s), int'(vd_s), int'(disp_s),
                  int'(hrow_s), int'(vcol_s), int'(ls_s), int'(fs_s)};
        end
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_en(input int sel, input logic v);
        if (sel == 0) pix_en_d = v;
        else          pix_en_s = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pix_en_d = 1'b0;
        pix_en_s = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pos = 0;
    endtask

    task automatic advance(input int sel, input int target);
        while (pos < target) begin
            set_en(sel, 1'b1);
            @(negedge clk);
            pos++;
        end
        set_en(sel, 1'b0);
    endtask

    task automatic chk_obs(input string tag, input obs_t o, input obs_t e);
        chk({tag, ".hsync"},   o.hs,   e.hs);
        chk({tag, ".vsync"},   o.vs,   e.vs);
        chk({tag, ".Hdisp"},   o.hd,   e.hd);
        chk({tag, ".Vdisp"},   o.vd,   e.vd);
        chk({tag, ".display"}, o.disp, e.disp);
        chk({tag, ".hrow"},    o.hrow, e.hrow);
        chk({tag, ".vcolumn"}, o.vcol, e.vcol);
        chk({tag, ".lstart"},  o.ls,   e.ls);
        chk({tag, ".fstart"},  o.fs,   e.fs);
    endtask

    task automatic measure(input int sel, input int div, input int ncyc,
                           output int ls_n, output int ls_a, output int ls_b,
                           output int fs_n, output int fs_b, output int hs_n,
                           output int vs_n, output int hd_n, output int vd_n,
                           output int hold_bad);
        obs_t o, prev;
        int pol;
        logic en;
        pol = (sel == 0) ? 0 : 1;
        ls_n = 0; ls_a = -1; ls_b = -1; fs_n = 0; fs_b = -1;
        hs_n = 0; vs_n = 0; hd_n = 0; vd_n = 0; hold_bad = 0;
        do_reset();
        prev = get_obs(sel);
        for (int c = 0; c < ncyc; c++) begin
            en = ((c % div) == 0);
            set_en(sel, en);
            @(negedge clk);
            o = get_obs(sel);
            if (o.ls != 0) begin
                if (ls_n == 0) ls_a = c;
                else if (ls_n == 1) ls_b = c;
                ls_n++;
            end
            if (o.fs != 0) begin
                if (fs_n == 1) fs_b = c;
                fs_n++;
            end
            if (o.hs == pol) hs_n++;
            if (o.vs == pol) vs_n++;
            if (o.hd != 0) hd_n++;
            if (o.vd != 0) vd_n++;
            if (!en) begin
                if (o.hs != prev.hs || o.vs != prev.vs || o.hd != prev.hd || o.vd != prev.vd ||
                    o.disp != prev.disp || o.hrow != prev.hrow || o.vcol != prev.vcol ||
                    o.ls != 0 || o.fs != 0)
                    hold_bad++;
            end
            prev = o;
        end
        set_en(sel, 1'b0);
    endtask

    task automatic run_measure(input int sel, input int div);
        int ls_n, ls_a, ls_b, fs_n, fs_b, hs_n, vs_n, hd_n, vd_n, hold_bad;
        string t;
        t = $sformatf("meas%0d_div%0d", sel, div);
        if (sel == 0) begin
            measure(0, div, 1600 * div, ls_n, ls_a, ls_b, fs_n, fs_b, hs_n, vs_n, hd_n, vd_n, hold_bad);
            chk({t, ".ls_count"},   ls_n, 2);
            chk({t, ".ls_first"},   ls_a, 0);
            chk({t, ".ls_period"},  ls_b, 800 * div);
            chk({t, ".fs_count"},   fs_n, 1);
            chk({t, ".hsync_low"},  hs_n, 2 * 96 * div);
            chk({t, ".vsync_low"},  vs_n, 0);
            chk({t, ".Hdisp_high"}, hd_n, 2 * 640 * div);
            chk({t, ".Vdisp_high"}, vd_n, 1600 * div);
        end else begin
            measure(1, div, 210 * div, ls_n, ls_a, ls_b, fs_n, fs_b, hs_n, vs_n, hd_n, vd_n, hold_bad);
            chk({t, ".ls_count"},   ls_n, 14);
            chk({t, ".ls_first"},   ls_a, 0);
            chk({t, ".ls_period"},  ls_b, 15 * div);
            chk({t, ".fs_count"},   fs_n, 2);
            chk({t, ".fs_period"},  fs_b, 105 * div);
            chk({t, ".hsync_high"}, hs_n, 14 * 3 * div);
            chk({t, ".vsync_high"}, vs_n, 2 * 15 * div);
            chk({t, ".Hdisp_high"}, hd_n, 14 * 8 * div);
            chk({t, ".Vdisp_high"}, vd_n, 2 * 60 * div);
        end
        chk({t, ".hold"}, hold_bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o, e;

        tbl = '{
            // sel, p, hs, vs, hd, vd, disp, hrow, vcol, ls, fs
            '{0,    1, 1, 1, 1, 1, 1,   0, 0, 1, 1},
            '{0,    2, 1, 1, 1, 1, 1,   1, 0, 0, 0},
            '{0,  640, 1, 1, 1, 1, 1, 639, 0, 0, 0},
            '{0,  641, 1, 1, 0, 1, 0,   0, 0, 0, 0},
            '{0,  656, 1, 1, 0, 1, 0,   0, 0, 0, 0},
            '{0,  657, 0, 1, 0, 1, 0,   0, 0, 0, 0},
            '{0,  752, 0, 1, 0, 1, 0,   0, 0, 0, 0},
            '{0,  753, 1, 1, 0, 1, 0,   0, 0, 0, 0},
            '{0,  800, 1, 1, 0, 1, 0,   0, 0, 0, 0},
            '{0,  801, 1, 1, 1, 1, 1,   0, 1, 1, 0},
            '{0, 1101, 1, 1, 1, 1, 1, 300, 1, 0, 0},
            '{0, 1441, 1, 1, 0, 1, 0,   0, 1, 0, 0},
            '{1,    1, 0, 0, 1, 1, 1,   0, 0, 1, 1},
            '{1,    8, 0, 0, 1, 1, 1,   7, 0, 0, 0},
            '{1,    9, 0, 0, 0, 1, 0,   0, 0, 0, 0},
            '{1,   11, 1, 0, 0, 1, 0,   0, 0, 0, 0},
            '{1,   13, 1, 0, 0, 1, 0,   0, 0, 0, 0},
            '{1,   14, 0, 0, 0, 1, 0,   0, 0, 0, 0},
            '{1,   16, 0, 0, 1, 1, 1,   0, 1, 1, 0},
            '{1,   50, 0, 0, 1, 1, 1,   4, 3, 0, 0},
            '{1,   61, 0, 0, 1, 0, 0,   0, 0, 1, 0},
            '{1,   76, 0, 1, 1, 0, 0,   0, 0, 1, 0},
            '{1,   87, 1, 1, 0, 0, 0,   0, 0, 0, 0},
            '{1,   91, 0, 0, 1, 0, 0,   0, 0, 1, 0},
            '{1,  105, 0, 0, 0, 0, 0,   0, 0, 0, 0},
            '{1,  106, 0, 0, 1, 1, 1,   0, 0, 1, 1}
        };

        // Reset state on both instances (held with pix_en low after release).
        do_reset();
        e = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        chk_obs("reset_d", get_obs(0), e);
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        chk_obs("reset_s", get_obs(1), e);

        // Directed vectors at full rate.
        for (int i = 0; i < NV; i++) begin
            if (i == 0 || tbl[i].sel != tbl[i-1].sel) do_reset();
            advance(tbl[i].sel, tbl[i].p);
            o = get_obs(tbl[i].sel);
            e = '{tbl[i].hs, tbl[i].vs, tbl[i].hd, tbl[i].vd, tbl[i].disp,
                  tbl[i].hrow, tbl[i].vcol, tbl[i].ls, tbl[i].fs};
            chk_obs($sformatf("vec%0d", i), o, e);
        end

        // Periods, region lengths and strobe widths at full and quarter rate.
        run_measure(0, 1);
        run_measure(0, 4);
        run_measure(1, 1);
        run_measure(1, 4);

        // Mid-frame reset with pix_en held high: reset wins, then restart at (0,0).
        do_reset();
        advance(0, 1901);
        chk("midrst.pre_hrow", int'(hrow_d), 300);
        chk("midrst.pre_vcol", int'(vcol_d), 2);
        rst = 1'b1;
        pix_en_d = 1'b1;
        @(negedge clk);
        e = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        chk_obs("midrst.in", get_obs(0), e);
        rst = 1'b0;
        @(negedge clk);
        pix_en_d = 1'b0;
        e = '{1, 1, 1, 1, 1, 0, 0, 1, 1};
        chk_obs("midrst.first", get_obs(0), e);
        @(negedge clk);
        chk("midrst.ls_width", int'(ls_d), 0);
        chk("midrst.fs_width", int'(fs_d), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
